demux1to2_64bit_buf: RTL and testbench
======================================

Name: demux1to2_64bit_buf

Overview:
- Inverse of the 64-bit 2:1 word mux: takes one stream of 64-bit binarized character bitmaps (8x8 pixels) and routes each word to one of two consumers.
- Typical consumers: two neural-network inference lanes, or the classifier path and a debug capture path.
- Each output has a one-entry registered buffer with a valid/ready handshake, so a stalled consumer never corrupts a word.
- Routing is by an explicit select or by strict round-robin.

Parameters:
- IWIDTH, 64, data word width in bits.
- ROUTE_MODE, 0, 0 = route by in_sel; 1 = strict round-robin (in_sel ignored).
- CNT_WIDTH, 16, width of the per-output delivered-word counters (optional feature only).

Ports:
- clk  in  1  single system clock; all logic rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- in_data  in  IWIDTH  input word.
- in_sel  in  1  destination: 0 = out0, 1 = out1 (ROUTE_MODE=0 only).
- in_valid  in  1  input word present.
- in_ready  out  1  block accepts the word this cycle.
- out0_data  out  IWIDTH  channel 0 word.
- out0_valid  out  1  channel 0 word present.
- out0_ready  in  1  channel 0 consumer accepts.
- out1_data  out  IWIDTH  channel 1 word.
- out1_valid  out  1  channel 1 word present.
- out1_ready  in  1  channel 1 consumer accepts.
- cnt0, cnt1  out  CNT_WIDTH each  delivered-word counts (present only with DEMUX_STATS_EN).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - outN_valid=0, outN_data=0, round-robin pointer rr=0, counters=0.
  - Any buffered word is discarded.
  - in_ready is forced 0 while rst_n=0.
- Target select: tgt = in_sel if ROUTE_MODE=0; tgt = rr if ROUTE_MODE=1.
- Ready: in_ready = ~outT_valid | outT_ready, where T=tgt. This is combinational from outT_ready, so the buffer can refill in the same cycle it drains.
- Accept: when in_valid & in_ready, the word and a valid flag load into buffer T at the next edge.
  - Latency is 1 cycle from accept to outT_valid=1.
  - Sustained throughput is 1 word/cycle while the target consumer keeps ready=1.
- Drain: when outN_valid & outN_ready, outN_valid clears at the next edge unless a new accept to N occurs in that same cycle. In that case outN_valid stays 1 and outN_data takes the new word.
- Hold: while outN_valid & ~outN_ready, outN_data and outN_valid are stable.
- Round-robin:
  - rr toggles only on an accepted word; a stall does not toggle it.
  - Strict alternation: if the target buffer is busy, the input stalls even when the other buffer is empty. This preserves word order per lane.
- The non-target buffer is unaffected by input activity; both outputs may drain in the same cycle.
- in_valid=1 with in_ready=0: the word is not taken. in_data and in_sel must be held by the producer; the block latches nothing.
- ROUTE_MODE=0 with in_sel changing while stalled: the new in_sel is honoured and ready is re-evaluated against the new target.
- No internal state other than the two buffers, rr, and the counters.

Optional Feature:
- Macro: DEMUX_STATS_EN.
- Defined:
  - cnt0/cnt1 ports exist. cntN increments by 1 on each outN handshake (outN_valid & outN_ready).
  - Counters wrap at 2^CNT_WIDTH to 0 and reset to 0.
- Undefined: cnt ports and counter logic are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - IWIDTH and CNT_WIDTH defaults.
  - Route-mode constants: ROUTE_SEL=0, ROUTE_RR=1.
  - The 64-bit word type.
- One natural sub-module: out_slot_64bit, a single-entry valid/ready register slot instantiated twice.

Test Plan:
1. Reset behaviour: rst_n=0 for 2 cycles with in_valid=1 -> in_ready=0, out0_valid=out1_valid=0, data=0. Release -> first word accepted next cycle.
2. Select routing, ROUTE_MODE=0, outN_ready=1: send 64'hFFC19C3E7E7C01FF with sel=0, then 64'h0123456789ABCDEF with sel=1 -> out0 shows word 1 one cycle after its accept; out1 shows word 2 one cycle later.
3. Backpressure: out0_ready=0, two sel=0 words -> first held stable on out0, in_ready=0 for the second. Raise out0_ready -> second word appears the following cycle with no gap.
4. Round-robin, ROUTE_MODE=1: 6 words 1..6 -> out0 gets 1,3,5 and out1 gets 2,4,6. With out1_ready=0 after word 2, input stalls before word 4 even though out0 is empty.
5. Reset mid-operation: both buffers full and stalled, assert rst_n=0 one cycle -> both valids 0, rr=0, buffered words lost.
6. Stats (DEMUX_STATS_EN, CNT_WIDTH=4): 17 words to out0 -> cnt0=1 after wrap, cnt1=0.

Source files
------------

// File: rtl/demux1to2_64bit_buf_pkg.sv
// Shared constants and word type for the 1:2 buffered bitmap demux.
// Optional feature macro: DEMUX_STATS_EN (per-output delivered-word counters).
package demux1to2_64bit_buf_pkg;

  localparam int IWIDTH_DEF    = 64;
  localparam int CNT_WIDTH_DEF = 16;

  localparam int ROUTE_SEL = 0;
  localparam int ROUTE_RR  = 1;

  typedef logic [IWIDTH_DEF-1:0] word_t;

endpackage

// File: rtl/demux1to2_64bit_buf_out_slot.sv
// Single-entry valid/ready register slot; can drain and refill in one cycle.
// Unaffected by DEMUX_STATS_EN.
module out_slot_64bit
  import demux1to2_64bit_buf_pkg::*;
#(
  parameter int W = IWIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux1to2_64bit_buf.sv
// 1:2 demux of 64-bit bitmap words into two registered valid/ready slots,
// routed by in_sel or strict round-robin. Macro DEMUX_STATS_EN adds cnt0/cnt1.
module demux1to2_64bit_buf
  import demux1to2_64bit_buf_pkg::*;
#(
  parameter int IWIDTH     = IWIDTH_DEF,
  parameter int ROUTE_MODE = ROUTE_SEL
`ifdef DEMUX_STATS_EN
  ,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IWIDTH-1:0] in_data,
  input  logic              in_sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [IWIDTH-1:0] out0_data,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [IWIDTH-1:0] out1_data,
  output logic              out1_valid,
  input  logic              out1_ready
`ifdef DEMUX_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] cnt0,
  output logic [CNT_WIDTH-1:0] cnt1
`endif
);

  logic              rr;
  logic              tgt;
  logic              accept;
  logic [1:0]        slot_valid;
  logic [1:0]        slot_ready;
  logic [1:0]        slot_load;
  logic [IWIDTH-1:0] slot_data [2];

  assign slot_ready = {out1_ready, out0_ready};
  assign tgt        = (ROUTE_MODE == ROUTE_RR) ? rr : in_sel;

  // Ready looks only at the target slot: strict alternation keeps per-lane order.
  assign in_ready = rst_n & (~slot_valid[tgt] | slot_ready[tgt]);
  assign accept   = in_valid & in_ready;

  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    assign slot_load[gi] = accept & (tgt == 1'(gi));

    out_slot_64bit #(
      .W(IWIDTH)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (slot_load[gi]),
      .load_data(in_data),
      .ready    (slot_ready[gi]),
      .valid    (slot_valid[gi]),
      .data     (slot_data[gi])
    );
  end

  assign out0_valid = slot_valid[0];
  assign out1_valid = slot_valid[1];
  assign out0_data  = slot_data[0];
  assign out1_data  = slot_data[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr <= 1'b0;
    end else if (accept && (ROUTE_MODE == ROUTE_RR)) begin
      rr <= ~rr;
    end
  end

`ifdef DEMUX_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (out0_valid && out0_ready) cnt0 <= cnt0 + 1'b1;
      if (out1_valid && out1_ready) cnt1 <= cnt1 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_demux1to2_64bit_buf.sv
// Bench for demux1to2_64bit_buf: select-mode and round-robin instances share stimulus.
// Counter checks compile in only with DEMUX_STATS_EN.
module tb_demux1to2_64bit_buf;
  import demux1to2_64bit_buf_pkg::*;

  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] in_data;
  logic        in_sel;
  logic        in_valid;
  logic        out0_ready;
  logic        out1_ready;

  // Index [m][n]: m = instance (0 select, 1 round-robin), n = lane.
  logic [1:0]            dir;
  logic [1:0][1:0]       dv;
  logic [1:0][1:0][63:0] dd;
`ifdef DEMUX_STATS_EN
  logic [1:0][1:0][CW-1:0] dc;
`endif

  int checks = 0;
  int errors = 0;
  bit model_ok = 0;
  logic [63:0] lane0_log[$];
  logic [63:0] lane1_log[$];

  always #5 clk = ~clk;

  demux1to2_64bit_buf #(
    .IWIDTH(64), .ROUTE_MODE(ROUTE_SEL)
`ifdef DEMUX_STATS_EN
    , .CNT_WIDTH(CW)
`endif
  ) u_sel (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(dir[0]),
    .out0_data(dd[0][0]), .out0_valid(dv[0][0]), .out0_ready(out0_ready),
    .out1_data(dd[0][1]), .out1_valid(dv[0][1]), .out1_ready(out1_ready)
`ifdef DEMUX_STATS_EN
    , .cnt0(dc[0][0]), .cnt1(dc[0][1])
`endif
  );

  demux1to2_64bit_buf #(
    .IWIDTH(64), .ROUTE_MODE(ROUTE_RR)
`ifdef DEMUX_STATS_EN
    , .CNT_WIDTH(CW)
`endif
  ) u_rr (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(dir[1]),
    .out0_data(dd[1][0]), .out0_valid(dv[1][0]), .out0_ready(out0_ready),
    .out1_data(dd[1][1]), .out1_valid(dv[1][1]), .out1_ready(out1_ready)
`ifdef DEMUX_STATS_EN
    , .cnt0(dc[1][0]), .cnt1(dc[1][1])
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each lane is "holding a word or empty"; rr flips per accepted word.
  logic [1:0]    mv [2];
  logic [63:0]   md [2][2];
  logic          mrr [2];
  logic [CW-1:0] mc [2][2];

  initial begin
    for (int m = 0; m < 2; m++) begin
      mv[m] = '0; mrr[m] = 1'b0;
      for (int n = 0; n < 2; n++) begin md[m][n] = '0; mc[m][n] = '0; end
    end
    forever begin
      @(negedge clk);
      if (model_ok) begin
        for (int m = 0; m < 2; m++) begin
          logic t;
          logic [1:0] rd;
          rd = {out1_ready, out0_ready};
          t = (m == 1) ? mrr[m] : in_sel;
          chk($sformatf("in_ready[%0d]", m), 64'(dir[m]),
              64'(rst_n && (!mv[m][t] || rd[t])));
          for (int n = 0; n < 2; n++) begin
            chk($sformatf("valid[%0d][%0d]", m, n), 64'(dv[m][n]), 64'(mv[m][n]));
            if (mv[m][n]) chk($sformatf("data[%0d][%0d]", m, n), dd[m][n], md[m][n]);
`ifdef DEMUX_STATS_EN
            chk($sformatf("cnt[%0d][%0d]", m, n), 64'(dc[m][n]), 64'(mc[m][n]));
`endif
          end
        end
      end
      if (rst_n && dv[1][0] && out0_ready) lane0_log.push_back(dd[1][0]);
      if (rst_n && dv[1][1] && out1_ready) lane1_log.push_back(dd[1][1]);
      @(posedge clk);
      for (int m = 0; m < 2; m++) begin
        logic t, rdy, acc;
        logic [1:0] rd;
        rd  = {out1_ready, out0_ready};
        t   = (m == 1) ? mrr[m] : in_sel;
        rdy = rst_n && (!mv[m][t] || rd[t]);
        acc = in_valid && rdy;
        if (!rst_n) begin
          mv[m] = '0; mrr[m] = 1'b0;
          for (int n = 0; n < 2; n++) begin md[m][n] = '0; mc[m][n] = '0; end
        end else begin
          for (int n = 0; n < 2; n++) begin
            logic hs;
            hs = mv[m][n] && rd[n];
            if (hs) mc[m][n] = mc[m][n] + 1'b1;
            if (acc && (t == 1'(n))) begin
              mv[m][n] = 1'b1;
              md[m][n] = in_data;
            end else if (hs) begin
              mv[m][n] = 1'b0;
            end
          end
          if (acc && m == 1) mrr[m] = ~mrr[m];
        end
      end
      if (!rst_n) model_ok = 1;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present a word and hold it until instance m accepts it; in_valid is left high.
  task automatic send(input logic [63:0] w, input logic s, input int m);
    int n;
    in_data = w; in_sel = s; in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (dir[m]) begin tick(); break; end
      tick();
      n++;
      if (n > 50) begin
        checks++; errors++;
        $display("FAIL send_timeout: got no in_ready expected accept of %h", w);
        break;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; in_sel = 1'b0; in_data = 64'hDEAD_BEEF_0000_0001;
    out0_ready = 1'b1; out1_ready = 1'b1;

    // Reset with in_valid held high
    tick();
    @(negedge clk);
    chk("rst_in_ready", 64'(dir[0]), 64'd0);
    chk("rst_out0_valid", 64'(dv[0][0]), 64'd0);
    chk("rst_out1_valid", 64'(dv[0][1]), 64'd0);
    chk("rst_out0_data", dd[0][0], 64'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 64'(dir[0]), 64'd1);
    tick();
    in_valid = 1'b0;
    repeat (2) tick();

    // Select routing
    send(64'hFFC19C3E7E7C01FF, 1'b0, 0);
    in_data = 64'h0123456789ABCDEF; in_sel = 1'b1;
    @(negedge clk);
    chk("sel_w1_valid", 64'(dv[0][0]), 64'd1);
    chk("sel_w1_data", dd[0][0], 64'hFFC19C3E7E7C01FF);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("sel_w2_valid", 64'(dv[0][1]), 64'd1);
    chk("sel_w2_data", dd[0][1], 64'h0123456789ABCDEF);
    chk("sel_w1_drained", 64'(dv[0][0]), 64'd0);
    tick();

    // Backpressure on out0
    out0_ready = 1'b0;
    send(64'hAAAA_0000_0000_000A, 1'b0, 0);
    in_data = 64'hBBBB_0000_0000_000B;
    @(negedge clk);
    chk("bp_hold_data", dd[0][0], 64'hAAAA_0000_0000_000A);
    chk("bp_stall", 64'(dir[0]), 64'd0);
    tick();
    @(negedge clk);
    chk("bp_hold_data2", dd[0][0], 64'hAAAA_0000_0000_000A);
    chk("bp_stall2", 64'(dir[0]), 64'd0);
    tick();
    out0_ready = 1'b1;
    @(negedge clk);
    chk("bp_refill_ready", 64'(dir[0]), 64'd1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_second_valid", 64'(dv[0][0]), 64'd1);
    chk("bp_second_data", dd[0][0], 64'hBBBB_0000_0000_000B);
    tick();

    // Round-robin with out1 stalled
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    lane0_log.delete(); lane1_log.delete();
    out0_ready = 1'b1; out1_ready = 1'b0;
    send(64'd1, 1'b0, 1);
    send(64'd2, 1'b0, 1);
    send(64'd3, 1'b0, 1);
    in_data = 64'd4;
    @(negedge clk);
    chk("rr_stall_ready", 64'(dir[1]), 64'd0);
    tick();
    @(negedge clk);
    chk("rr_out0_empty", 64'(dv[1][0]), 64'd0);
    chk("rr_stall_ready2", 64'(dir[1]), 64'd0);
    tick();
    out1_ready = 1'b1;
    send(64'd4, 1'b0, 1);
    send(64'd5, 1'b0, 1);
    send(64'd6, 1'b0, 1);
    in_valid = 1'b0;
    repeat (4) tick();
    chk("rr_lane0_count", 64'(lane0_log.size()), 64'd3);
    chk("rr_lane1_count", 64'(lane1_log.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < lane0_log.size()) chk($sformatf("rr_lane0_%0d", i), lane0_log[i], 64'(2*i+1));
      if (i < lane1_log.size()) chk($sformatf("rr_lane1_%0d", i), lane1_log[i], 64'(2*i+2));
    end

    // Reset mid-operation, both slots full and rr pointing at lane 1
    out0_ready = 1'b1; out1_ready = 1'b0;
    send(64'h11, 1'b0, 1);
    send(64'h22, 1'b0, 1);
    out0_ready = 1'b0;
    send(64'h33, 1'b0, 1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_v0", 64'(dv[1][0]), 64'd1);
    chk("full_v1", 64'(dv[1][1]), 64'd1);
    tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_v0", 64'(dv[1][0]), 64'd0);
    chk("midrst_v1", 64'(dv[1][1]), 64'd0);
    tick();
    out0_ready = 1'b1; out1_ready = 1'b1;
    send(64'hC0C0_C0C0_C0C0_C0C0, 1'b1, 1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_rr0_valid", 64'(dv[1][0]), 64'd1);
    chk("midrst_rr0_data", dd[1][0], 64'hC0C0_C0C0_C0C0_C0C0);
    tick();

`ifdef DEMUX_STATS_EN
    // Counter wrap: 17 words to out0
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int i = 0; i < 17; i++) send(64'(i + 100), 1'b0, 0);
    in_valid = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk("stats_cnt0_wrap", 64'(dc[0][0]), 64'd1);
    chk("stats_cnt1", 64'(dc[0][1]), 64'd0);
    tick();
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst_n      = ($urandom_range(0, 99) != 0);
      in_valid   = ($urandom_range(0, 3) != 0);
      in_sel     = 1'($urandom);
      in_data    = {$urandom, $urandom};
      out0_ready = ($urandom_range(0, 2) != 0);
      out1_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
